des_round_ctrl: RTL and testbench
=================================

# des_round_ctrl

Sequencing controller for the iterative DES datapath. It accepts a block request through a start/ready handshake and latches the encrypt/decrypt mode. It then drives the Feistel half-registers (`load_init`, `en`) and the key-schedule shifter (amount, direction, load) through exactly 16 rounds. It presents the result through a valid/ready handshake. It sits directly upstream of the left/right half registers and the key schedule, and replaces ad-hoc testbench driving of `load_init`/`en`.

## Interface
- `ROUNDS`, default 16: number of Feistel rounds. Only 16 is supported for DES. The parameter exists for reduced-round debug builds (range 2..16).
- `clk` input 1: system clock, rising-edge.
- `rst` input 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `start` input 1: request to process one block; qualified by `in_ready`.
- `decrypt` input 1: mode, sampled only on start acceptance (0 = encrypt, 1 = decrypt).
- `in_ready` output 1: high only in IDLE.
- `load_init` output 1: one-cycle pulse; the half registers load L_0/R_0.
- `en` output 1: half-register round update enable.
- `key_load` output 1: one-cycle pulse, coincident with `load_init`; the key schedule loads PC-1(key).
- `key_shift` output 2: rotate amount applied this round (0, 1 or 2).
- `key_dir` output 1: 0 = rotate left (encrypt), 1 = rotate right (decrypt).
- `round_idx` output 4: current round number 0..ROUNDS-1; 0 outside ROUND.
- `busy` output 1: high in LOAD, ROUND and DONE.
- `out_valid` output 1: result halves are final and stable.
- `out_ready` input 1: consumer accepts the result.

## Operation
- States:
  - **IDLE**: in_ready=1. `start` moves to LOAD and latches `decrypt` into `mode_q`.
  - **LOAD**: exactly 1 cycle. `load_init`=1, `key_load`=1, `en`=0. Always moves to ROUND with idx=0.
  - **ROUND**: `en`=1 for exactly ROUNDS consecutive cycles, idx 0..ROUNDS-1. At idx=ROUNDS-1, moves to DONE.
  - **DONE**: `en`=0, `out_valid`=1, holding until `out_valid && out_ready`, then IDLE.
- Key shift per round index 0..15:
  - Encrypt (left): 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decrypt (right): 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- `key_shift`=0 outside ROUND. `key_dir` = `mode_q` (held after completion until the next accept).
- `start` while not in IDLE: ignored; no queueing.
- `decrypt` changes after acceptance: no effect on the current block.
- `out_ready` outside DONE: ignored.
- Async reset asserted mid-operation: immediate return to IDLE with every output at its reset value. Half-register contents are don't-care until the next LOAD.
- Reset values: in_ready=1; all other outputs 0. Internal state: `mode_q`=0, round counter=0.

## Timing
- Start accepted at rising edge E0. LOAD is active in cycle E0→E1, and the half registers load at E1.
- Round updates occur at edges E2..E(ROUNDS+1).
- `out_valid` rises after E(ROUNDS+1): 17 edges after acceptance for ROUNDS=16.
- Throughput with `out_ready` tied high: one block per 19 cycles (accept + LOAD + 16 ROUND + DONE).
- `in_ready` reasserts the cycle after the DONE handshake. A back-to-back `start` is accepted on that edge.
- All outputs are registered or decoded from the state register only, with no combinational path from inputs to outputs. Exception: `in_ready` depends on state only.
- The round counter is 4 bits and saturates conceptually at ROUNDS-1. It must never wrap into an extra round.

## Structure
- Shared package `des_pkg`:
  - state enum (IDLE, LOAD, ROUND, DONE)
  - `DES_ROUNDS` = 16
  - 16-entry 2-bit shift-schedule constant
- Optional sub-module `des_shift_sched`: combinational lookup of (round_idx, mode) → `key_shift`. Everything else lives in one module.

## Test plan
- **Reset:** `rst`=0 for 2 cycles → in_ready=1, all other outputs 0. Release, 5 idle cycles → still idle.
- **Encrypt block:** start=1, decrypt=0 for 1 cycle, out_ready=1, integrated with the half registers (L_0=AAAA5555) → load_init pulses exactly once, en is high exactly 16 cycles, key_shift sequence matches the encrypt table, key_dir=0, out_valid after 17 edges, in_ready returns.
- **Decrypt block:** decrypt=1 → key_dir=1, first key_shift=0, remaining sequence matches the decrypt table.
- **Backpressure:** out_ready=0 for 10 cycles in DONE → out_valid held, en=0, half registers unchanged. out_ready=1 → IDLE next cycle. start held high throughout → second block accepted immediately after.
- **Ignored inputs:** start pulse and decrypt toggle during ROUND idx=7 → no restart, mode unchanged, round count still 16.
- **Reset mid-run:** rst=0 for 10 ns at idx=5 → outputs reset immediately. A new start runs a full 16-round sequence from idx 0.

Source files
------------

// File: rtl/des_pkg.sv
// Shared types and constants for the iterative DES round controller.
package des_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int DES_ROUNDS = 16;

    // Left-rotate amount per round; element 0 is round 0.
    localparam logic [15:0][1:0] SHIFT_SCHED = {
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
        2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1
    };

endpackage

// File: rtl/des_shift_sched.sv
// Key-schedule rotate amount for the current round and direction.
module des_shift_sched
    import des_pkg::*;
(
    input  logic       active,
    input  logic       mode,
    input  logic [3:0] round_idx,
    output logic [1:0] key_shift
);

    // Decryption starts from the encrypt end state (C16 = C0), so round 0 does not rotate.
    always_comb begin
        key_shift = 2'd0;
        if (active) begin
            if (mode && (round_idx == 4'd0)) begin
                key_shift = 2'd0;
            end else begin
                key_shift = SHIFT_SCHED[round_idx];
            end
        end
    end

endmodule

// File: rtl/des_round_ctrl.sv
// Sequencer for the iterative DES datapath: load, ROUNDS Feistel rounds, result handshake.
//
// state   | meaning
// IDLE    | waiting for start, in_ready high
// LOAD    | one cycle: load L0/R0 and PC-1(key)
// ROUND   | en high, round_idx 0..ROUNDS-1
// DONE    | out_valid high until out_ready
module des_round_ctrl
    import des_pkg::*;
#(
    parameter int ROUNDS = DES_ROUNDS
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       decrypt,
    input  logic       out_ready,
    output logic       in_ready,
    output logic       load_init,
    output logic       en,
    output logic       key_load,
    output logic [1:0] key_shift,
    output logic       key_dir,
    output logic [3:0] round_idx,
    output logic       busy,
    output logic       out_valid
);

    localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mode_q, mode_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    mode_d  = decrypt;
                end
            end
            S_LOAD: begin
                state_d = S_ROUND;
                cnt_d   = 4'd0;
            end
            S_ROUND: begin
                // Terminal-count compare stops the counter before it can wrap into an extra round.
                if (cnt_q == LAST_IDX) begin
                    state_d = S_DONE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign load_init = (state_q == S_LOAD);
    assign key_load  = (state_q == S_LOAD);
    assign en        = (state_q == S_ROUND);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign key_dir   = mode_q;
    assign round_idx = en ? cnt_q : 4'd0;

    des_shift_sched u_shift_sched (
        .active    (en),
        .mode      (mode_q),
        .round_idx (cnt_q),
        .key_shift (key_shift)
    );

endmodule

// File: tb/tb_des_round_ctrl.sv
// Directed bench for des_round_ctrl with a toy half-register model on load_init/en.
module tb_des_round_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, decrypt, out_ready;
    logic       in_ready, load_init, en, key_load, key_dir, busy, out_valid;
    logic [1:0] key_shift;
    logic [3:0] round_idx;

    logic [31:0] l_half, r_half;

    int checks = 0;
    int errors = 0;

    int enc_tab [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [31:0] L_FINAL = 32'hAAAA_5565;
    localparam logic [31:0] R_FINAL = 32'h0001_0000;

    always #5 clk = ~clk;

    des_round_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .decrypt   (decrypt),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .load_init (load_init),
        .en        (en),
        .key_load  (key_load),
        .key_shift (key_shift),
        .key_dir   (key_dir),
        .round_idx (round_idx),
        .busy      (busy),
        .out_valid (out_valid)
    );

    // L counts rounds, R rotates a single bit: after 16 rounds L=AAAA5565, R=00010000.
    always_ff @(posedge clk) begin
        if (load_init) begin
            l_half <= 32'hAAAA_5555;
            r_half <= 32'h0000_0001;
        end else if (en) begin
            l_half <= l_half + 32'd1;
            r_half <= {r_half[30:0], r_half[31]};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_shift(input int idx, input logic dec);
        if (dec && idx == 0) return 32'd0;
        return 32'(enc_tab[idx]);
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  in_ready,  1);
        check({tag, "_load_init"}, load_init, 0);
        check({tag, "_key_load"},  key_load,  0);
        check({tag, "_en"},        en,        0);
        check({tag, "_key_shift"}, key_shift, 0);
        check({tag, "_key_dir"},   key_dir,   0);
        check({tag, "_round_idx"}, round_idx, 0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_out_valid"}, out_valid, 0);
    endtask

    // Caller presents start/decrypt at a negedge while idle; returns at the negedge back in IDLE.
    task automatic run_block(input logic dec, input int stall, input bit hold_start, input bit poke);
        int en_cnt = 0;
        int ld_cnt = 0;
        int edges  = 0;
        out_ready = (stall == 0);
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        decrypt = ~dec;
        check("load_pulse",  load_init, 1);
        check("key_load",    key_load,  1);
        check("load_en",     en,        0);
        check("load_inrdy",  in_ready,  0);
        check("load_busy",   busy,      1);
        check("load_shift",  key_shift, 0);
        while (!out_valid && edges < 40) begin
            @(negedge clk);
            edges++;
            if (load_init) ld_cnt++;
            if (en) begin
                check("round_idx", round_idx, en_cnt);
                check("key_shift", key_shift, exp_shift(en_cnt, dec));
                check("key_dir",   key_dir,   dec);
                if (poke && en_cnt == 7) begin
                    start   = 1'b1;
                    decrypt = ~decrypt;
                end else if (poke && en_cnt == 8) begin
                    start = 1'b0;
                end
                en_cnt++;
            end
        end
        check("valid_latency", edges,  17);
        check("en_cycles",     en_cnt, 16);
        check("no_restart",    ld_cnt, 0);
        check("done_shift",    key_shift, 0);
        check("done_idx",      round_idx, 0);
        check("done_dir",      key_dir,   dec);
        check("l_final",       l_half, L_FINAL);
        check("r_final",       r_half, R_FINAL);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_en",    en,        0);
            check("bp_inrdy", in_ready,  0);
            check("bp_l",     l_half,    L_FINAL);
            check("bp_r",     r_half,    R_FINAL);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("ret_inrdy", in_ready,  1);
        check("ret_valid", out_valid, 0);
        check("ret_busy",  busy,      0);
    endtask

    initial begin
        start     = 1'b0;
        decrypt   = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check_idle("idle5");

        start = 1'b1; decrypt = 1'b0;
        run_block(1'b0, 0, 1'b0, 1'b0);
        check_idle("after_enc");

        start = 1'b1; decrypt = 1'b1;
        run_block(1'b1, 0, 1'b0, 1'b0);
        check("dir_held", key_dir, 1);

        // Backpressure with start held: the second block must be accepted on the return edge.
        start = 1'b1; decrypt = 1'b0;
        run_block(1'b0, 10, 1'b1, 1'b0);
        decrypt = 1'b1;
        run_block(1'b1, 0, 1'b0, 1'b0);

        start = 1'b1; decrypt = 1'b1;
        run_block(1'b1, 0, 1'b0, 1'b1);

        start = 1'b1; decrypt = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 30 && !(en && round_idx == 4'd5); t++) @(negedge clk);
        check("idx5_reached", {31'd0, en && (round_idx == 4'd5)}, 1);
        #2 rst = 1'b0;
        #1 check_idle("midrst");
        #9 rst = 1'b1;
        @(negedge clk);
        check_idle("post_rst");
        start = 1'b1; decrypt = 1'b0;
        run_block(1'b0, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
